// File: rtl/control_fsm.sv
// Multi-cycle fetch/exec/wait control unit for the accumulator CPU.
// Optional `CTRL_BRANCH_EN enables BEQ/BNE/JMP; without it those opcodes decode as NOP.
module control_fsm #(
  parameter int PC_W     = 11,
  parameter int INSTR_W  = 16,
  parameter int OPCODE_W = 5,
  parameter int RAM_LAT  = 1
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic [INSTR_W-1:0]             i_Instr,
  input  logic                           i_InstrValid,
  input  logic                           i_AccZero,
  output logic [PC_W-1:0]                o_Addr,
  output logic [INSTR_W-OPCODE_W-1:0]    o_Operand,
  output logic [OPCODE_W-1:0]            o_Opcode,
  output logic [1:0]                     o_SelA,
  output logic                           o_SelB,
  output logic                           o_Op,
  output logic                           o_WrAcc,
  output logic                           o_WrRam,
  output logic                           o_RdRam,
  output logic                           o_Halt
);

  localparam int OPER_W = INSTR_W - OPCODE_W;

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [OPCODE_W-1:0] OP_HLT  = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_STO  = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_LD   = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_LDI  = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_SUBI = OPCODE_W'(7);
`ifdef CTRL_BRANCH_EN
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(9);
  localparam logic [OPCODE_W-1:0] OP_JMP  = OPCODE_W'(10);
`endif

  logic [1:0]          state;
  logic [PC_W-1:0]     pc;
  logic [PC_W-1:0]     pc_next;
  logic [INSTR_W-1:0]  ir;
  logic [1:0]          wait_cnt;
  logic [OPCODE_W-1:0] opcode;
  logic [OPER_W-1:0]   operand;
  logic                is_ram_acc;
  logic                is_imm_acc;
  logic                wait_last;
  logic [1:0]          sel_a_dec;
  logic                sel_b_dec;
  logic                op_dec;

  // Operand is truncated or zero-extended to the PC width.
  function automatic logic [PC_W-1:0] branch_target(input logic [OPER_W-1:0] opnd);
    return PC_W'(opnd);
  endfunction

  assign opcode     = ir[INSTR_W-1 -: OPCODE_W];
  assign operand    = ir[OPER_W-1:0];
  assign is_ram_acc = (opcode == OP_LD) || (opcode == OP_ADD) || (opcode == OP_SUB);
  assign is_imm_acc = (opcode == OP_LDI) || (opcode == OP_ADDI) || (opcode == OP_SUBI);
  assign wait_last  = (wait_cnt == 2'(RAM_LAT - 1));

  assign o_Addr    = pc;
  assign o_Opcode  = opcode;
  assign o_Operand = operand;

  always_comb begin
    sel_a_dec = 2'd0;
    sel_b_dec = 1'b0;
    op_dec    = 1'b0;
    case (opcode)
      OP_LDI:  begin sel_a_dec = 2'd1; sel_b_dec = 1'b1; end
      OP_ADD:  sel_a_dec = 2'd2;
      OP_ADDI: begin sel_a_dec = 2'd2; sel_b_dec = 1'b1; end
      OP_SUB:  begin sel_a_dec = 2'd2; op_dec = 1'b1; end
      OP_SUBI: begin sel_a_dec = 2'd2; sel_b_dec = 1'b1; op_dec = 1'b1; end
      default: ;
    endcase
  end

  // Strobes depend only on state and IR; WAIT keeps the read and mux selects steady.
  always_comb begin
    o_SelA  = 2'd0;
    o_SelB  = 1'b0;
    o_Op    = 1'b0;
    o_WrAcc = 1'b0;
    o_WrRam = 1'b0;
    o_RdRam = 1'b0;
    o_Halt  = 1'b0;
    case (state)
      S_EXEC: begin
        o_SelA  = sel_a_dec;
        o_SelB  = sel_b_dec;
        o_Op    = op_dec;
        o_Halt  = (opcode == OP_HLT);
        o_WrRam = (opcode == OP_STO);
        o_RdRam = is_ram_acc;
        o_WrAcc = is_imm_acc || (is_ram_acc && (RAM_LAT == 0));
      end
      S_WAIT: begin
        o_SelA  = sel_a_dec;
        o_SelB  = sel_b_dec;
        o_Op    = op_dec;
        o_RdRam = 1'b1;
        o_WrAcc = wait_last;
      end
      S_HALT:  o_Halt = 1'b1;
      default: ;
    endcase
  end

`ifdef CTRL_BRANCH_EN
  always_comb begin
    pc_next = pc + PC_W'(1);
    case (opcode)
      OP_BEQ:  if (i_AccZero)  pc_next = branch_target(operand);
      OP_BNE:  if (!i_AccZero) pc_next = branch_target(operand);
      OP_JMP:  pc_next = branch_target(operand);
      default: ;
    endcase
  end
`else
  logic unused_acc_zero;
  logic [PC_W-1:0] unused_target;
  assign unused_acc_zero = i_AccZero;
  assign unused_target   = branch_target(operand);
  assign pc_next         = pc + PC_W'(1);
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= S_FETCH;
      pc       <= '0;
      ir       <= '0;
      wait_cnt <= 2'd0;
    end else begin
      case (state)
        S_FETCH: begin
          if (i_InstrValid) begin
            ir    <= i_Instr;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          wait_cnt <= 2'd0;
          if (opcode == OP_HLT) begin
            state <= S_HALT;
          end else if (is_ram_acc && (RAM_LAT != 0)) begin
            state <= S_WAIT;
          end else begin
            state <= S_FETCH;
            pc    <= pc_next;
          end
        end
        S_WAIT: begin
          if (wait_last) begin
            state <= S_FETCH;
            pc    <= pc + PC_W'(1);
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        default: state <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: per-instruction timeline model with random stimulus.
module tb_control_fsm;
  localparam int PC_W = 11, INSTR_W = 16, OPCODE_W = 5, RAM_LAT = 2;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [15:0] i_Instr = '0;
  logic        i_InstrValid = 1'b0;
  logic        i_AccZero = 1'b0;
  logic [10:0] o_Addr;
  logic [10:0] o_Operand;
  logic [4:0]  o_Opcode;
  logic [1:0]  o_SelA;
  logic        o_SelB, o_Op, o_WrAcc, o_WrRam, o_RdRam, o_Halt;

  control_fsm #(.PC_W(PC_W), .INSTR_W(INSTR_W), .OPCODE_W(OPCODE_W), .RAM_LAT(RAM_LAT)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_Instr(i_Instr), .i_InstrValid(i_InstrValid),
    .i_AccZero(i_AccZero), .o_Addr(o_Addr), .o_Operand(o_Operand), .o_Opcode(o_Opcode),
    .o_SelA(o_SelA), .o_SelB(o_SelB), .o_Op(o_Op), .o_WrAcc(o_WrAcc), .o_WrRam(o_WrRam),
    .o_RdRam(o_RdRam), .o_Halt(o_Halt)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [10:0] m_pc;
  logic [15:0] m_ir;

  // Strobe vector: {halt, sel_a[1:0], sel_b, op, wr_acc, wr_ram, rd_ram}
  function automatic logic [7:0] obs_vec();
    return {o_Halt, o_SelA, o_SelB, o_Op, o_WrAcc, o_WrRam, o_RdRam};
  endfunction

  task automatic apply_reset();
    i_reset = 1'b1;
    i_InstrValid = 1'b0;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    m_pc = '0;
    m_ir = '0;
  endtask

  // Fetch one instruction after `gap` stall cycles, then check every exec/wait cycle.
  // acc: 0/1 forces i_AccZero during EXEC, anything else randomizes it.
  task automatic do_instr(input logic [15:0] ins, input int gap, input int acc, input string tag);
    logic [7:0] exp_q[$];
    logic [7:0] base;
    logic [4:0] op;
    logic       acc_v;
    int         nc;
    op = ins[15:11];
    for (int g = 0; g < gap; g++) begin
      n_checks++;
      if ({o_Addr, o_Opcode, o_Operand, obs_vec()} !== {m_pc, m_ir, 8'h00}) begin
        n_fail++;
        $display("FAIL %s stall%0d: addr/ir/strb=%h/%h/%h required %h/%h/00",
                 tag, g, o_Addr, {o_Opcode, o_Operand}, obs_vec(), m_pc, m_ir);
      end
      i_InstrValid = 1'b0;
      i_Instr = 16'($urandom);
      i_AccZero = 1'($urandom);
      @(negedge i_clk);
    end
    n_checks++;
    if ({o_Addr, obs_vec()} !== {m_pc, 8'h00}) begin
      n_fail++;
      $display("FAIL %s fetch: addr/strb=%h/%h required %h/00", tag, o_Addr, obs_vec(), m_pc);
    end
    i_Instr = ins;
    i_InstrValid = 1'b1;
    @(negedge i_clk);
    m_ir = ins;
    nc = RAM_LAT + 1;
    case (op)
      5'd0: exp_q.push_back(8'h80);
      5'd1: exp_q.push_back(8'h02);
      5'd2, 5'd4, 5'd6: begin
        base = (op == 5'd2) ? 8'h01 : ((op == 5'd4) ? 8'h41 : 8'h49);
        for (int k = 0; k < nc; k++) exp_q.push_back(base | ((k == nc - 1) ? 8'h04 : 8'h00));
      end
      5'd3: exp_q.push_back(8'h34);
      5'd5: exp_q.push_back(8'h54);
      5'd7: exp_q.push_back(8'h5C);
      default: exp_q.push_back(8'h00);
    endcase
    acc_v = (acc == 0 || acc == 1) ? 1'(acc) : 1'($urandom);
    for (int k = 0; k < exp_q.size(); k++) begin
      n_checks++;
      if ({o_Addr, o_Opcode, o_Operand, obs_vec()} !== {m_pc, ins, exp_q[k]}) begin
        n_fail++;
        $display("FAIL %s exec%0d: addr/ir/strb=%h/%h/%h required %h/%h/%h",
                 tag, k, o_Addr, {o_Opcode, o_Operand}, obs_vec(), m_pc, ins, exp_q[k]);
      end
      i_InstrValid = 1'($urandom);
      i_Instr = 16'($urandom);
      i_AccZero = (k == 0) ? acc_v : 1'($urandom);
      @(negedge i_clk);
    end
    i_InstrValid = 1'b0;
    if (op != 5'd0) begin
      m_pc = m_pc + 11'd1;
`ifdef CTRL_BRANCH_EN
      if ((op == 5'd8 && acc_v) || (op == 5'd9 && !acc_v) || op == 5'd10) m_pc = ins[10:0];
`endif
    end
  endtask

  task automatic check_halt_hold(input int cycles, input string tag);
    for (int c = 0; c < cycles; c++) begin
      i_InstrValid = 1'($urandom);
      i_Instr = 16'($urandom);
      n_checks++;
      if ({o_Addr, obs_vec()} !== {m_pc, 8'h80}) begin
        n_fail++;
        $display("FAIL %s halt%0d: addr/strb=%h/%h required %h/80", tag, c, o_Addr, obs_vec(), m_pc);
      end
      @(negedge i_clk);
    end
    i_InstrValid = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    i_reset = 1'b1;
    @(negedge i_clk);
    n_checks++;
    if ({o_Addr, o_Opcode, o_Operand, obs_vec()} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: addr/ir/strb=%h/%h/%h required all zero",
               o_Addr, {o_Opcode, o_Operand}, obs_vec());
    end
    i_reset = 1'b0;
  endtask

  task automatic test_immediate();
    apply_reset();
    do_instr({5'd3, 11'd5}, 0, 2, "ldi");
    do_instr({5'd5, 11'd3}, 0, 2, "addi");
    do_instr({5'd0, 11'd0}, 0, 2, "hlt");
    check_halt_hold(4, "imm_halt");
  endtask

  task automatic test_ram_wait();
    apply_reset();
    do_instr({5'd4, 11'd7}, 0, 2, "add7");
    do_instr({5'd2, 11'd9}, 1, 2, "ld");
    do_instr({5'd6, 11'd1}, 0, 2, "sub");
    do_instr({5'd1, 11'd4}, 0, 2, "sto");
  endtask

  task automatic test_reset_mid_wait();
    apply_reset();
    i_Instr = {5'd4, 11'd7};
    i_InstrValid = 1'b1;
    @(negedge i_clk);
    i_InstrValid = 1'b0;
    n_checks++;
    if (obs_vec() !== 8'h41) begin
      n_fail++;
      $display("FAIL rst_wait exec: strb=%h required 41", obs_vec());
    end
    @(negedge i_clk);
    n_checks++;
    if (obs_vec() !== 8'h41) begin
      n_fail++;
      $display("FAIL rst_wait wait1: strb=%h required 41", obs_vec());
    end
    i_reset = 1'b1;
    @(negedge i_clk);
    n_checks++;
    if ({o_Addr, o_Opcode, o_Operand, obs_vec()} !== '0) begin
      n_fail++;
      $display("FAIL rst_wait after: addr/ir/strb=%h/%h/%h required all zero",
               o_Addr, {o_Opcode, o_Operand}, obs_vec());
    end
    i_reset = 1'b0;
    m_pc = '0;
    m_ir = '0;
    do_instr({5'd3, 11'd1}, 0, 2, "post_rst");
  endtask

  task automatic test_branch();
    apply_reset();
    do_instr({5'd8, 11'h040}, 0, 1, "beq_taken");
    do_instr({5'd8, 11'h040}, 0, 0, "beq_not");
    do_instr({5'd9, 11'h123}, 0, 0, "bne_taken");
    do_instr({5'd9, 11'h200}, 0, 1, "bne_not");
    do_instr({5'd10, 11'h3F0}, 0, 2, "jmp");
    do_instr({5'd31, 11'h000}, 0, 2, "nop_after");
  endtask

  task automatic test_valid_stall();
    apply_reset();
    do_instr({5'd3, 11'h055}, 0, 2, "pre_stall");
    do_instr({5'd5, 11'h002}, 4, 2, "stall4");
  endtask

  task automatic test_wrap();
    logic [4:0] op;
    int guard;
    apply_reset();
    guard = 0;
    while (m_pc != 11'h7FF && guard < 4000) begin
      op = 5'($urandom_range(1, 28));
      if (op >= 5'd8) op = op + 5'd3;
      do_instr({op, 11'($urandom)}, int'($urandom_range(0, 1)), 2, "walk");
      guard++;
    end
    n_checks++;
    if (m_pc != 11'h7FF) begin
      n_fail++;
      $display("FAIL wrap_reach: model pc=%h required 7ff", m_pc);
    end
    do_instr({5'd31, 11'h5A5}, 0, 2, "nop_wrap");
    n_checks++;
    if (o_Addr !== 11'h000) begin
      n_fail++;
      $display("FAIL wrap_pc: addr=%h required 000", o_Addr);
    end
    do_instr({5'd0, 11'h000}, 1, 2, "hlt_wrap");
    check_halt_hold(6, "wrap_halt");
    i_reset = 1'b1;
    @(negedge i_clk);
    n_checks++;
    if ({o_Addr, o_Opcode, o_Operand, obs_vec()} !== '0) begin
      n_fail++;
      $display("FAIL halt_reset: addr/ir/strb=%h/%h/%h required all zero",
               o_Addr, {o_Opcode, o_Operand}, obs_vec());
    end
    i_reset = 1'b0;
    m_pc = '0;
    m_ir = '0;
  endtask

  task automatic test_random();
    logic [4:0] op;
    apply_reset();
    for (int n = 0; n < 300; n++) begin
      op = 5'($urandom);
      if (op == 5'd0) op = 5'd31;
      do_instr({op, 11'($urandom)}, int'($urandom_range(0, 2)), 2, "rand");
    end
  endtask

  initial begin
    m_pc = '0;
    m_ir = '0;
    @(negedge i_clk);
    test_reset();
    test_immediate();
    test_ram_wait();
    test_reset_mid_wait();
    test_branch();
    test_valid_stall();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
